fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the five-stage RV32I pipeline. It owns the PC, issues word reads to a synchronous instruction memory with fixed 1-cycle read latency, and buffers returned words in a 2-entry queue. It presents `instruction_type` words with their PC to the decode stage, which produces `control_type`. It honours decode back-pressure (hazard stall) and branch/jump redirects from EX, and sustains one instruction per cycle when not stalled.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `QUEUE_DEPTH`, default 2: instruction queue entries. Minimum 2, which is required for full throughput.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  read request this cycle. The memory always accepts.
- `imem_addr`  out  32  byte address of the request; bits [1:0] are always 0.
- `imem_rdata`  in  32  read data for the request issued the previous cycle.
- `redirect`  in  1  taken branch or jump from EX. Squashes all younger fetches.
- `redirect_target`  in  32  new PC. Bits [1:0] are ignored and forced to 0.
- `id_valid`  out  1  queue head holds a valid instruction.
- `id_ready`  in  1  decode accepts the head this cycle. Low means stall.
- `id_instr`  out  32  head instruction, as `common::instruction_type`.
- `id_pc`  out  32  PC of the head instruction.

## Operation
- State:
  - `pc`: next sequential fetch address.
  - `inflight`: 1 bit, a request was issued last cycle.
  - Circular queue of {instr, pc} with head/tail pointers and `count` (0..QUEUE_DEPTH).
- Pop: `pop = id_valid & id_ready & ~redirect`.
- Issue rule, normal cycle: `imem_req = (count + inflight - pop) < QUEUE_DEPTH`.
  - `imem_addr = pc`.
  - On issue, `pc <= pc + 4`. Addition is 32-bit modulo, so 32'hFFFF_FFFC wraps to 0.
- Response: if `inflight` and not `redirect`, enqueue {`imem_rdata`, address issued last cycle} at the tail.
- Redirect cycle (highest priority):
  - The queue is flushed to `count = 0`. Pop and enqueue are both suppressed.
  - A response arriving this cycle is discarded.
  - `imem_req = 1` and `imem_addr = {redirect_target[31:2], 2'b00}`.
  - `pc <= that target + 4`.
  - `inflight <= 1`.
- Simultaneous pop and enqueue: `count` is unchanged and both pointers advance.
- Overflow cannot occur, because the issue rule reserves a slot for every in-flight response. Verification asserts `count <= QUEUE_DEPTH` at all times.
- Full queue with stall: `imem_req = 0` and `pc` holds until a pop frees a slot.
- `id_valid = (count != 0)`. `id_instr` and `id_pc` come from registers at the queue head with no combinational path from `imem_rdata`.
- While `redirect` is high, `id_valid` may still be 1. The consumer squashes via the same `redirect`, and no pop occurs.

## Timing
- Reset (asynchronous assert):
  - `pc = RESET_PC`, `inflight = 0`, `count = 0`, pointers = 0.
  - Outputs: `id_valid = 0`, `imem_req = 0` while `reset_n` is low. `id_instr` and `id_pc` read 0.
- Reset asserted mid-operation clears everything immediately; the in-flight response is lost.
- Cycle 0, the first edge after `reset_n` deassertion: `imem_req = 1`, `imem_addr = RESET_PC`.
- Fetch-to-decode latency is 2 cycles.
  - Request in cycle N, data enqueued at the end of N+1, `id_valid` in N+2.
- Steady state with `id_ready = 1`: one request and one delivered instruction per cycle, consecutive PCs.
- Redirect in cycle N:
  - `id_valid = 0` in N+1.
  - `id_valid = 1` in N+2 with `id_pc = target`.
  - Redirect penalty is 2 bubbles at fetch output.
- Back-to-back redirects in N and N+1: the second wins, and the N request's data is discarded in N+1.
- Stall release: the head is presented in the same cycle `id_ready` rises, and is popped at the end of that cycle.

## Test plan
- Reset then free-run with `RESET_PC = 0` and a memory returning `addr ^ 32'hA5A5_0000`:
  - `id_valid` first high in cycle 2 with `id_pc = 0`.
  - Then `id_pc = 4, 8, 12...` every cycle with matching data and no bubbles.
- Stall `id_ready = 0` for 5 cycles starting with `id_pc = 8` at the head:
  - `count` reaches 2 and `imem_req` goes low.
  - On release, PCs 8, 12, 16 are delivered in consecutive cycles with none lost or duplicated.
- Redirect to 32'h0000_0103 in cycle 10 with an in-flight request:
  - `imem_addr = 32'h100` in cycle 10.
  - `id_valid = 0` in cycle 11.
  - `id_pc = 32'h100` in cycle 12, then 32'h104.
- Redirect during a full-queue stall: both queued entries are dropped and the next delivered `id_pc` is the target.
- Back-to-back redirects to 32'h200 then 32'h300: the first delivered `id_pc` is 32'h300 and 32'h200 never appears.
- `reset_n` pulsed low mid-stream for half a cycle:
  - `id_valid` and `imem_req` drop asynchronously.
  - After release, fetch restarts at `RESET_PC`.
- PC wrap: redirect to 32'hFFFF_FFF8 delivers `id_pc` FFFF_FFF8, FFFF_FFFC, then 0.

Source files
------------

// File: rtl/fetch_stage.sv
// RV32I fetch: owns the PC, issues 1-cycle-latency imem reads and buffers words in a small queue.
// Fetch-to-decode latency 2 cycles; decode stall holds the queue head and throttles requests.
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   last_addr_q, last_addr_d;
  logic          inflight_q, inflight_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [31:0]   instr_q [QUEUE_DEPTH];
  logic [31:0]   qpc_q   [QUEUE_DEPTH];

  logic [31:0] tgt_al;
  logic        pop;
  logic        enq;
  logic        issue;
  logic [CW:0] occ;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(QUEUE_DEPTH - 1)) return '0;
    else return p + PW'(1);
  endfunction

  assign tgt_al = redirect_target & 32'hFFFF_FFFC;
  assign id_valid = (count_q != '0);
  assign pop = id_valid & id_ready & ~redirect;
  assign enq = inflight_q & ~redirect;

  // Slots already owed to an in-flight response count as occupied, so the queue cannot overflow.
  assign occ   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
  assign issue = (occ < (CW+1)'(QUEUE_DEPTH));

  assign imem_req  = reset_n & (redirect | issue);
  assign imem_addr = redirect ? tgt_al : pc_q;
  assign id_instr  = instr_q[head_q];
  assign id_pc     = qpc_q[head_q];

  always_comb begin
    pc_d        = pc_q;
    last_addr_d = last_addr_q;
    inflight_d  = inflight_q;
    count_d     = count_q;
    head_d      = head_q;
    tail_d      = tail_q;
    if (redirect) begin
      pc_d        = tgt_al + 32'd4;
      last_addr_d = tgt_al;
      inflight_d  = 1'b1;
      count_d     = '0;
      head_d      = '0;
      tail_d      = '0;
    end else begin
      count_d    = count_q + CW'(enq) - CW'(pop);
      inflight_d = issue;
      if (pop) head_d = ptr_inc(head_q);
      if (enq) tail_d = ptr_inc(tail_q);
      if (issue) begin
        pc_d        = pc_q + 32'd4;
        last_addr_d = pc_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q        <= RESET_PC & 32'hFFFF_FFFC;
      last_addr_q <= '0;
      inflight_q  <= 1'b0;
      count_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        instr_q[i] <= '0;
        qpc_q[i]   <= '0;
      end
    end else begin
      pc_q        <= pc_d;
      last_addr_q <= last_addr_d;
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      if (enq) begin
        instr_q[tail_q] <= imem_rdata;
        qpc_q[tail_q]   <= last_addr_q;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised bench for fetch_stage against a queue-level model of the fetch rules.
module tb_fetch_stage;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  fetch_stage #(.RESET_PC(32'h0), .QUEUE_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_target(redirect_target),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: PCs waiting in the queue, the outstanding request, next fetch address.
  logic [31:0] m_q[$];
  logic        m_infl;
  logic [31:0] m_infl_addr;
  logic [31:0] m_pc;

  logic        obs_valid, obs_req;
  logic [31:0] obs_pc, obs_addr;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_infl      = 1'b0;
    m_infl_addr = '0;
    m_pc        = 32'h0;
  endtask

  // Called at posedge+1: drive inputs, compare at negedge, then advance memory and model.
  task automatic cycle(input logic rdy, input logic redir, input logic [31:0] tgt);
    logic        exp_valid, exp_pop, exp_req;
    logic [31:0] exp_addr, al;
    int          occ;
    id_ready        = rdy;
    redirect        = redir;
    redirect_target = tgt;
    al = tgt & 32'hFFFF_FFFC;
    @(negedge clk);
    exp_valid = (m_q.size() != 0);
    exp_pop   = exp_valid && rdy && !redir;
    occ       = m_q.size() + int'(m_infl) - int'(exp_pop);
    exp_req   = redir || (occ < DEPTH);
    exp_addr  = redir ? al : m_pc;
    obs_valid = id_valid;
    obs_req   = imem_req;
    obs_pc    = id_pc;
    obs_addr  = imem_addr;
    check("id_valid", id_valid, exp_valid);
    check("imem_req", imem_req, exp_req);
    if (exp_req) check("imem_addr", imem_addr, exp_addr);
    if (exp_valid) begin
      check("id_pc", id_pc, m_q[0]);
      check("id_instr", id_instr, mem(m_q[0]));
    end
    @(posedge clk);
    #1;
    imem_rdata = obs_req ? mem(obs_addr) : $urandom;
    if (redir) begin
      m_q.delete();
      m_infl      = 1'b1;
      m_infl_addr = al;
      m_pc        = al + 32'd4;
    end else begin
      if (exp_pop) void'(m_q.pop_front());
      if (m_infl) m_q.push_back(m_infl_addr);
      m_infl = exp_req;
      if (exp_req) begin
        m_infl_addr = m_pc;
        m_pc        = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    logic [31:0] p;
    model_reset();
    #12;
    check("rst id_valid", id_valid, 0);
    check("rst imem_req", imem_req, 0);
    check("rst id_instr", id_instr, 0);
    check("rst id_pc", id_pc, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Free run from reset
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      if (i == 0) begin
        check("c0 req", obs_req, 1);
        check("c0 addr", obs_addr, 32'h0);
      end
      if (i == 1) check("c1 valid", obs_valid, 0);
      if (i >= 2) begin
        check("run valid", obs_valid, 1);
        check("run pc", obs_pc, 32'(4 * (i - 2)));
      end
    end

    // Stall five cycles then release
    p = 32'h0;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b0, 32'h0);
      if (k == 0) p = obs_pc;
      else check("stall req", obs_req, 0);
      check("stall pc", obs_pc, p);
    end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0, 32'h0);
      check("release valid", obs_valid, 1);
      check("release pc", obs_pc, p + 32'(4 * k));
    end

    // Redirect with a request in flight
    cycle(1'b1, 1'b1, 32'h0000_0103);
    check("redir addr", obs_addr, 32'h100);
    check("redir req", obs_req, 1);
    cycle(1'b1, 1'b0, 32'h0);
    check("redir+1 valid", obs_valid, 0);
    cycle(1'b1, 1'b0, 32'h0);
    check("redir+2 pc", obs_pc, 32'h100);
    cycle(1'b1, 1'b0, 32'h0);
    check("redir+3 pc", obs_pc, 32'h104);

    // Redirect while the queue is full and stalled
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h400);
    cycle(1'b1, 1'b0, 32'h0);
    check("full redir valid", obs_valid, 0);
    cycle(1'b1, 1'b0, 32'h0);
    check("full redir pc", obs_pc, 32'h400);

    // Back-to-back redirects
    cycle(1'b1, 1'b1, 32'h200);
    cycle(1'b1, 1'b1, 32'h300);
    check("b2b addr", obs_addr, 32'h300);
    cycle(1'b1, 1'b0, 32'h0);
    check("b2b valid", obs_valid, 0);
    cycle(1'b1, 1'b0, 32'h0);
    check("b2b pc0", obs_pc, 32'h300);
    cycle(1'b1, 1'b0, 32'h0);
    check("b2b pc1", obs_pc, 32'h304);

    // Mid-stream reset pulse
    id_ready = 1'b1;
    redirect = 1'b0;
    reset_n  = 1'b0;
    #2;
    check("pulse id_valid", id_valid, 0);
    check("pulse imem_req", imem_req, 0);
    check("pulse id_pc", id_pc, 0);
    #1;
    reset_n = 1'b1;
    model_reset();
    cycle(1'b1, 1'b0, 32'h0);
    check("restart addr", obs_addr, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    check("restart valid", obs_valid, 0);
    cycle(1'b1, 1'b0, 32'h0);
    check("restart pc", obs_pc, 32'h0);

    // PC wrap
    cycle(1'b1, 1'b1, 32'hFFFF_FFF8);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    check("wrap pc0", obs_pc, 32'hFFFF_FFF8);
    cycle(1'b1, 1'b0, 32'h0);
    check("wrap pc1", obs_pc, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b0, 32'h0);
    check("wrap pc2", obs_pc, 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] t;
      t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, t);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
